// File: rtl/timer_irq_ctrl_pkg.sv
// Shared definitions for the memory-mapped interval timer and interrupt sequencer:
// register offsets, TCON bit positions, FSM encoding and the bus offset decoder.
package timer_irq_ctrl_pkg;

  localparam logic [31:0] OFF_TH   = 32'h0000_0000;
  localparam logic [31:0] OFF_TL   = 32'h0000_0004;
  localparam logic [31:0] OFF_TCON = 32'h0000_0008;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_ST = 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] PEND = 2'd2;
  localparam logic [1:0] SERV = 2'd3;

  typedef enum logic [1:0] {
    REG_TH,
    REG_TL,
    REG_TCON,
    REG_NONE
  } reg_sel_e;

  // Exact-match decode: unaligned or out-of-range offsets land on REG_NONE.
  function automatic reg_sel_e decode_offset(input logic [31:0] offset);
    reg_sel_e sel;
    case (offset)
      OFF_TH:   sel = REG_TH;
      OFF_TL:   sel = REG_TL;
      OFF_TCON: sel = REG_TCON;
      default:  sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/timer_irq_ctrl_if.sv
// Data-memory bus slice seen by the timer block; the core side drives the
// request, the timer returns load data and its address-hit flag.
interface timer_irq_ctrl_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        MemWr;
  logic        MemRd;
  logic [31:0] rdata;
  logic        sel;

  modport master (
    output addr, wdata, MemWr, MemRd,
    input  rdata, sel
  );

  modport slave (
    input  addr, wdata, MemWr, MemRd,
    output rdata, sel
  );
endinterface

// File: rtl/timer_irq_ctrl_timer_core.sv
// TH reload register and TL up-counter; TL wraps to TH after all-ones and
// flags an overflow for that cycle.
module timer_core
  import timer_irq_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             th_we_i,
  input  logic             tl_we_i,
  input  logic [CNT_W-1:0] wdata_i,
  output logic [CNT_W-1:0] th_o,
  output logic [CNT_W-1:0] tl_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] th_q, th_d;
  logic [CNT_W-1:0] tl_q, tl_d;
  logic             wrap;

  assign wrap  = (tl_q == '1);
  // The overflow still fires when software overwrites TL on the wrap cycle,
  // so the status/missed accounting never loses an event.
  assign ovf_o = en_i && wrap;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    th_d = th_q;
    tl_d = tl_q;
    if (th_we_i) begin
      th_d = wdata_i;
    end
    if (tl_we_i) begin
      tl_d = wdata_i;
    end else if (en_i) begin
      tl_d = wrap ? th_q : tl_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample
  // their next-state values from the same pre-edge snapshot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q <= '0;
      tl_q <= '0;
    end else begin
      th_q <= th_d;
      tl_q <= tl_d;
    end
  end

  assign th_o = th_q;
  assign tl_o = tl_q;

endmodule

// File: rtl/timer_irq_ctrl.sv
// Interval timer plus interrupt handshake for the single-cycle MIPS core:
// bus decode, TCON, missed-overflow counter and the IDLE/RUN/PEND/SERV sequencer.
module timer_irq_ctrl
  import timer_irq_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          CNT_W     = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  timer_irq_ctrl_if.slave         bus,
  input  logic                    pchigh,
  output logic                    Interrupt,
  output logic [7:0]              missed
);

  logic [31:0] offset;
  reg_sel_e    reg_sel;
  logic        wr_en;
  logic        th_we, tl_we, tcon_we;

  logic [CNT_W-1:0] th_val, tl_val;
  logic             ovf;

  logic       en_q, en_d;
  logic       ie_q, ie_d;
  logic       st_q, st_d;
  logic [7:0] missed_q, missed_d;
  logic [1:0] state_q, state_d;
  logic [31:0] rdata_mux;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  assign offset  = bus.addr - BASE_ADDR;
  assign reg_sel = decode_offset(offset);
  assign bus.sel = (reg_sel != REG_NONE);

  assign wr_en   = bus.MemWr && bus.sel;
  assign th_we   = wr_en && (reg_sel == REG_TH);
  assign tl_we   = wr_en && (reg_sel == REG_TL);
  assign tcon_we = wr_en && (reg_sel == REG_TCON);

  timer_core #(
    .CNT_W (CNT_W)
  ) u_timer_core (
    .clk     (clk),
    .reset   (reset),
    .en_i    (en_q),
    .th_we_i (th_we),
    .tl_we_i (tl_we),
    .wdata_i (bus.wdata[CNT_W-1:0]),
    .th_o    (th_val),
    .tl_o    (tl_val),
    .ovf_o   (ovf)
  );

  // ---------------------------------------------------------------------------
  // TCON and missed-overflow counter
  // ---------------------------------------------------------------------------
  always_comb begin
    en_d     = en_q;
    ie_d     = ie_q;
    st_d     = st_q;
    missed_d = missed_q;

    if (tcon_we) begin
      en_d = bus.wdata[TCON_EN];
      ie_d = bus.wdata[TCON_IE];
      // Software may only clear status; writing a 1 leaves it unchanged.
      if (!bus.wdata[TCON_ST]) begin
        st_d = 1'b0;
      end
    end
    // Evaluated after the software clear so a coincident overflow wins.
    if (ovf && ie_q) begin
      st_d = 1'b1;
    end

    if (tcon_we) begin
      missed_d = '0;
    end else if (ovf && st_q && (missed_q != 8'hFF)) begin
      missed_d = missed_q + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt handshake sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (en_q) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (st_q) begin
          state_d = PEND;
        end else if (!en_q) begin
          state_d = IDLE;
        end
      end
      PEND: begin
        if (!st_q) begin
          state_d = en_q ? RUN : IDLE;
        end else if (pchigh) begin
          state_d = SERV;
        end
      end
      SERV: begin
        if (!st_q && !pchigh) begin
          state_d = en_q ? RUN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the asynchronous reset clears Interrupt immediately, without
  // waiting for a clock edge, because Interrupt decodes straight from state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q     <= 1'b0;
      ie_q     <= 1'b0;
      st_q     <= 1'b0;
      missed_q <= '0;
      state_q  <= IDLE;
    end else begin
      en_q     <= en_d;
      ie_q     <= ie_d;
      st_q     <= st_d;
      missed_q <= missed_d;
      state_q  <= state_d;
    end
  end

  assign Interrupt = (state_q == PEND);
  assign missed    = missed_q;

  // ---------------------------------------------------------------------------
  // Load data
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata_mux = '0;
    if (bus.MemRd) begin
      case (reg_sel)
        REG_TH:   rdata_mux = 32'(th_val);
        REG_TL:   rdata_mux = 32'(tl_val);
        REG_TCON: rdata_mux = {29'd0, st_q, ie_q, en_q};
        default:  rdata_mux = '0;
      endcase
    end
  end

  assign bus.rdata = rdata_mux;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed bench for timer_irq_ctrl: a register-access vector table followed by
// hand-written sequences for overflow, handshake, missed counting and reset.
module tb_timer_irq_ctrl;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic       clk = 1'b0;
  logic       reset;
  logic       pchigh;
  logic       Interrupt;
  logic [7:0] missed;

  timer_irq_ctrl_if bus ();

  timer_irq_ctrl #(
    .BASE_ADDR (BASE),
    .CNT_W     (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .pchigh    (pchigh),
    .Interrupt (Interrupt),
    .missed    (missed)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       name;
    logic        do_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_sel;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.MemWr = 1'b1;
    @(posedge clk);
    #1;
    bus.MemWr = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic s);
    bus.addr  = a;
    bus.MemRd = 1'b1;
    #1;
    d = bus.rdata;
    s = bus.sel;
    bus.MemRd = 1'b0;
  endtask

  task automatic check_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic        s;
    rd(a, d, s);
    check(name, d, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic        s;

    vecs[0] = '{"rst_th",     1'b0, BASE + 32'h0,  32'h0,         32'h0,         1'b1};
    vecs[1] = '{"rst_tl",     1'b0, BASE + 32'h4,  32'h0,         32'h0,         1'b1};
    vecs[2] = '{"rst_tcon",   1'b0, BASE + 32'h8,  32'h0,         32'h0,         1'b1};
    vecs[3] = '{"unmap_c",    1'b0, BASE + 32'hC,  32'h0,         32'h0,         1'b0};
    vecs[4] = '{"unalign_2",  1'b0, BASE + 32'h2,  32'h0,         32'h0,         1'b0};
    vecs[5] = '{"below_base", 1'b0, BASE - 32'h4,  32'h0,         32'h0,         1'b0};
    vecs[6] = '{"wr_th",      1'b1, BASE + 32'h0,  32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b1};
    vecs[7] = '{"wr_tl",      1'b1, BASE + 32'h4,  32'h0000_1234, 32'h0000_1234, 1'b1};
    vecs[8] = '{"wr_tcon_st", 1'b1, BASE + 32'h8,  32'h0000_0006, 32'h0000_0002, 1'b1};
    vecs[9] = '{"wr_tcon_0",  1'b1, BASE + 32'h8,  32'h0000_0000, 32'h0000_0000, 1'b1};

    reset     = 1'b1;
    pchigh    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.MemWr = 1'b0;
    bus.MemRd = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();

    check("rst_interrupt", {31'd0, Interrupt}, 32'd0);
    check("rst_missed", {24'd0, missed}, 32'd0);

    // Register access table (timer disabled throughout).
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].do_wr) wr(vecs[i].addr, vecs[i].wdata);
      rd(vecs[i].addr, d, s);
      check({vecs[i].name, "_rdata"}, d, vecs[i].exp_rdata);
      check({vecs[i].name, "_sel"}, {31'd0, s}, {31'd0, vecs[i].exp_sel});
    end

    // No load strobe: rdata must stay zero even on a hit.
    bus.addr  = BASE;
    bus.MemRd = 1'b0;
    #1;
    check("no_rd_rdata", bus.rdata, 32'h0);
    check("no_rd_sel", {31'd0, bus.sel}, 32'd1);

    // Count up to wrap, reload from TH and raise the interrupt.
    wr(BASE + 32'h0, 32'hFFFF_FFF0);
    wr(BASE + 32'h4, 32'hFFFF_FFFD);
    wr(BASE + 32'h8, 32'h0000_0003);
    check_reg("cnt_fd", BASE + 32'h4, 32'hFFFF_FFFD);
    tick();
    check_reg("cnt_fe", BASE + 32'h4, 32'hFFFF_FFFE);
    tick();
    check_reg("cnt_ff", BASE + 32'h4, 32'hFFFF_FFFF);
    check("irq_before_ovf", {31'd0, Interrupt}, 32'd0);
    tick();
    check_reg("cnt_reload", BASE + 32'h4, 32'hFFFF_FFF0);
    check_reg("tcon_status", BASE + 32'h8, 32'h0000_0007);
    check("irq_same_cycle", {31'd0, Interrupt}, 32'd0);
    tick();
    check("irq_raised", {31'd0, Interrupt}, 32'd1);

    // Handler entry, acknowledge, return, then a fresh overflow.
    pchigh = 1'b1;
    tick();
    check("irq_serv", {31'd0, Interrupt}, 32'd0);
    wr(BASE + 32'h8, 32'h0000_0003);
    pchigh = 1'b0;
    tick();
    check("irq_back_run", {31'd0, Interrupt}, 32'd0);
    check_reg("tcon_acked", BASE + 32'h8, 32'h0000_0003);
    wr(BASE + 32'h4, 32'hFFFF_FFFE);
    tick();
    check("irq_pre_ovf2", {31'd0, Interrupt}, 32'd0);
    tick();
    check("irq_ovf2_cycle", {31'd0, Interrupt}, 32'd0);
    tick();
    check("irq_reraised", {31'd0, Interrupt}, 32'd1);
    check("missed_zero", {24'd0, missed}, 32'd0);

    // Back-to-back overflows with status already set.
    wr(BASE + 32'h0, 32'hFFFF_FFFF);
    wr(BASE + 32'h4, 32'hFFFF_FFFF);
    repeat (3) tick();
    check("missed_three", {24'd0, missed}, 32'd3);
    // TCON store coincides with an overflow: status set wins, missed clears.
    wr(BASE + 32'h8, 32'h0000_0003);
    check("missed_cleared", {24'd0, missed}, 32'd0);
    check_reg("tcon_set_wins", BASE + 32'h8, 32'h0000_0007);
    check("irq_still_pend", {31'd0, Interrupt}, 32'd1);

    // Asynchronous reset in PEND, well before the next clock edge.
    reset = 1'b1;
    #1;
    check("rst_async_irq", {31'd0, Interrupt}, 32'd0);
    check_reg("rst_async_th", BASE + 32'h0, 32'h0);
    check_reg("rst_async_tl", BASE + 32'h4, 32'h0);
    check_reg("rst_async_tcon", BASE + 32'h8, 32'h0);
    check("rst_async_missed", {24'd0, missed}, 32'd0);
    tick();
    reset = 1'b0;

    // TL store on the wrap cycle wins over the reload.
    wr(BASE + 32'h0, 32'hFFFF_FFF0);
    wr(BASE + 32'h4, 32'hFFFF_FFFE);
    wr(BASE + 32'h8, 32'h0000_0001);
    check_reg("tlw_start", BASE + 32'h4, 32'hFFFF_FFFE);
    tick();
    check_reg("tlw_ff", BASE + 32'h4, 32'hFFFF_FFFF);
    wr(BASE + 32'h4, 32'h0000_0005);
    check_reg("tlw_wins", BASE + 32'h4, 32'h0000_0005);
    check_reg("tlw_no_status", BASE + 32'h8, 32'h0000_0001);
    tick();
    check_reg("tlw_resume", BASE + 32'h4, 32'h0000_0006);

    // Missed counter saturates at 8'hFF.
    wr(BASE + 32'h0, 32'hFFFF_FFFF);
    wr(BASE + 32'h4, 32'hFFFF_FFFF);
    wr(BASE + 32'h8, 32'h0000_0003);
    repeat (260) tick();
    check("missed_sat", {24'd0, missed}, 32'h0000_00FF);
    check("irq_sat_pend", {31'd0, Interrupt}, 32'd1);
    pchigh = 1'b1;
    tick();
    check("irq_sat_serv", {31'd0, Interrupt}, 32'd0);
    wr(BASE + 32'h8, 32'h0000_0000);
    check("missed_sat_clr", {24'd0, missed}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/timer_irq_ctrl.md
Name: timer_irq_ctrl

Overview:
- Memory-mapped interval timer and interrupt sequencer for the single-cycle MIPS core.
- Raises the core's Interrupt input on timer overflow and holds it until the core enters kernel mode (pchigh=1).
- Masks re-entry while the handler runs; software acknowledges by clearing the status bit.
- Sits on the data-memory bus beside RAM, decoded by address.

Parameters:
- BASE_ADDR, 32'h4000_0000, byte address of register block (TH at +0, TL at +4, TCON at +8).
- CNT_W, 32, width of TH/TL counter registers.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- addr  input  32  data-bus byte address (ALU result)
- wdata  input  32  store data
- MemWr  input  1  store strobe from control
- MemRd  input  1  load strobe from control
- pchigh  input  1  PC[31]; 1 = kernel mode / handler running
- rdata  output  32  load data, combinational
- sel  output  1  addr hits this block (BASE_ADDR..BASE_ADDR+8, word-aligned); top level muxes rdata vs RAM
- Interrupt  output  1  interrupt request to core control
- missed  output  8  saturating count of overflows that occurred while status already set

Behaviour:
- Reset (async):
  - TH=0, TL=0, TCON=0, missed=0, state=IDLE, Interrupt=0.
  - rdata follows the combinational rule below.
- Registers:
  - TH: reload value.
  - TL: up-counter.
  - TCON[0]: enable. TCON[1]: irq enable. TCON[2]: status (sticky). TCON[31:3] read 0.
- Reads:
  - rdata = selected register when MemRd && sel, else 0.
  - Unaligned or unmapped offsets give sel=0.
- Writes take effect at the clk edge when MemWr && sel.
- Counting:
  - While TCON[0]=1, TL increments by 1 every cycle.
  - When TL == all-ones, the next TL is TH (wrap/reload) and an overflow event fires that cycle.
- Overflow event:
  - If TCON[1]=1 and TCON[2]=0, set TCON[2].
  - If TCON[2] is already 1, increment missed, saturating at 8'hFF.
- FSM states:
  - IDLE: TCON[0]=0. Go to RUN when TCON[0]=1.
  - RUN: counting, Interrupt=0. Go to PEND when TCON[2] becomes 1. Go to IDLE if TCON[0] is cleared.
  - PEND: Interrupt=1. Go to SERV on the first cycle with pchigh=1. If software clears TCON[2] first, go to RUN.
  - SERV: Interrupt=0. Go to RUN when TCON[2]=0 and pchigh=0 (handler returned).
- Interrupt is a registered output: Interrupt = (state==PEND).
- Entering PEND while pchigh is already 1: stay in PEND with Interrupt=1. The core gates it with ~pchigh; go to SERV on the next cycle.
- Clearing TCON[0] in PEND or SERV:
  - Counting stops.
  - The FSM still completes the handshake; go to IDLE instead of RUN on exit.
- Simultaneous events:
  - Software write to TL and overflow in the same cycle: the write wins, no reload.
  - Software write to TCON clearing bit 2 and an overflow setting it in the same cycle: the set wins, so no event is lost.
  - A write to TCON[2] with value 1 is ignored; software can only clear it.
- Writing missed: any store to TCON also clears missed.
- Reset mid-handshake returns everything to reset values immediately and drops Interrupt asynchronously.

Decomposition:
- Shared package holds:
  - register offsets (OFF_TH=0, OFF_TL=4, OFF_TCON=8);
  - TCON bit indices (TCON_EN, TCON_IE, TCON_ST);
  - FSM state encoding (IDLE, RUN, PEND, SERV).
- One sub-module, timer_core: TH/TL registers, reload logic and overflow pulse.
- Parent keeps the bus decode, TCON, the FSM and the missed counter.

Test Plan:
- Reset, then read TH/TL/TCON/addr 0x4000000C -> rdata 0, 0, 0, and sel=0 for +C.
- TH=32'hFFFF_FFF0, TL=32'hFFFF_FFFD, TCON=3 -> TL counts FE, FF, then reloads FFFF_FFF0; TCON reads 7; Interrupt=1 one cycle after status sets.
- In PEND, drive pchigh=1 -> Interrupt=0 next cycle (SERV). Write TCON=3, drop pchigh -> state RUN; next overflow re-raises Interrupt.
- With status set, force 3 more overflows (TH=TL=all-ones) -> missed=3. Write TCON -> missed=0.
- Same cycle as overflow, write TCON=3 (clearing status) -> TCON still reads 7. In a separate case, same cycle as overflow, write TL=5 -> TL=5 and no reload.
- Assert reset while in PEND -> Interrupt=0 before the next clk edge; all registers 0.
